// File: rtl/dm_pkg.sv
// Shared entry layout, funct3 / error-code encodings and FSM state for the store drain.
package dm_pkg;

    localparam int unsigned EntryW  = 74;
    localparam int unsigned AddrLsb = 42;
    localparam int unsigned AddrW   = 32;
    localparam int unsigned DataLsb = 10;
    localparam int unsigned DataW   = 32;
    localparam int unsigned F3Lsb   = 7;
    localparam int unsigned F3W     = 3;
    localparam int unsigned IdLsb   = 0;
    localparam int unsigned IdW     = 7;

    localparam logic [2:0] F3Sb = 3'b000;
    localparam logic [2:0] F3Sh = 3'b001;
    localparam logic [2:0] F3Sw = 3'b010;

    localparam logic [1:0] ErrNone     = 2'b00;
    localparam logic [1:0] ErrMisalign = 2'b01;
    localparam logic [1:0] ErrFunct3   = 2'b10;
    localparam logic [1:0] ErrTimeout  = 2'b11;

    typedef enum logic {
        StIdle = 1'b0,
        StReq  = 1'b1
    } state_e;

endpackage

// File: rtl/dm_store_align.sv
// Store lane steering: byte strobes, replicated write data and legality of one store entry.
module dm_store_align
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    always_comb begin
        wdata_o      = data_i;
        wstrb_o      = 4'b0000;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (funct3_i)
            F3Sb: begin
                wdata_o = {4{data_i[7:0]}};
                wstrb_o = 4'b0001 << addr_lo_i;
            end
            F3Sh: begin
                wdata_o      = {2{data_i[15:0]}};
                wstrb_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misaligned_o = addr_lo_i[0];
            end
            F3Sw: begin
                wstrb_o      = 4'b1111;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_store_drain.sv
// Drains the MEM-stage store FIFO into data memory over a req/ack handshake.
// Optional request timeout is enabled by defining DM_DRAIN_TIMEOUT_EN.
module dm_store_drain
    import dm_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [EntryW-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              dm_req,
    output logic [31:0]       dm_addr,
    output logic [31:0]       dm_wdata,
    output logic [3:0]        dm_wstrb,
    input  logic              dm_ack,
    output logic              st_done,
    output logic              st_err,
    output logic [1:0]        st_err_code,
    output logic [6:0]        st_id,
    output logic              drain_busy
);

    logic [AddrW-1:0] head_addr;
    logic [DataW-1:0] head_data;
    logic [F3W-1:0]   head_f3;
    logic [IdW-1:0]   head_id;
    logic [31:0]      head_wdata;
    logic [3:0]       head_wstrb;
    logic             head_misal, head_illegal, head_ok;
    logic [1:0]       head_code;

    assign head_addr = fifo_data[AddrLsb +: AddrW];
    assign head_data = fifo_data[DataLsb +: DataW];
    assign head_f3   = fifo_data[F3Lsb +: F3W];
    assign head_id   = fifo_data[IdLsb +: IdW];

    dm_store_align u_align (
        .addr_lo_i    (head_addr[1:0]),
        .funct3_i     (head_f3),
        .data_i       (head_data),
        .wdata_o      (head_wdata),
        .wstrb_o      (head_wstrb),
        .misaligned_o (head_misal),
        .illegal_o    (head_illegal)
    );

    assign head_ok   = ~head_misal & ~head_illegal;
    assign head_code = head_illegal ? ErrFunct3 : ErrMisalign;

    state_e         state_q, state_d;
    logic [31:0]    addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]     wstrb_q, wstrb_d;
    logic [IdW-1:0] id_q, id_d, st_id_q, st_id_d;
    logic           done_q, done_d, err_q, err_d;
    logic [1:0]     code_q, code_d;
    logic           tmo, fin;

`ifdef DM_DRAIN_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign tmo   = (state_q == StReq) && !dm_ack && (cnt_q == CntW'(TIMEOUT - 1));
    assign cnt_d = ((state_q == StReq) && !fin) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo            = 1'b0;
`endif

    assign fin = (state_q == StReq) && (dm_ack || tmo);

    // Illegal heads are only popped from IDLE, so st_err never lands on a st_done cycle.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        id_d       = id_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        code_d     = ErrNone;
        st_id_d    = st_id_q;
        fifo_rd_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    if (head_ok) begin
                        addr_d  = {head_addr[31:2], 2'b00};
                        wdata_d = head_wdata;
                        wstrb_d = head_wstrb;
                        id_d    = head_id;
                        state_d = StReq;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = head_code;
                        st_id_d = head_id;
                    end
                end
            end
            StReq: begin
                if (fin) begin
                    st_id_d = id_q;
                    if (dm_ack) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ErrTimeout;
                    end
                    if (!fifo_empty && head_ok) begin
                        fifo_rd_en = 1'b1;
                        addr_d     = {head_addr[31:2], 2'b00};
                        wdata_d    = head_wdata;
                        wstrb_d    = head_wstrb;
                        id_d       = head_id;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            id_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ErrNone;
            st_id_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            id_q    <= id_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            st_id_q <= st_id_d;
        end
    end

    assign dm_req      = (state_q == StReq);
    assign dm_addr     = addr_q;
    assign dm_wdata    = wdata_q;
    assign dm_wstrb    = wstrb_q;
    assign st_done     = done_q;
    assign st_err      = err_q;
    assign st_err_code = code_q;
    assign st_id       = st_id_q;
    assign drain_busy  = (state_q != StIdle) || !fifo_empty;

endmodule
